// File: rtl/buffer_port_ctrl.sv
// buffer_port_ctrl: sequences router write/read/mark requests into four-phase flit buffer handshakes.
// Optional handshake timeout with hs_err pulse when BUFFER_PORT_CTRL_TIMEOUT_EN is defined.
module buffer_port_ctrl #(
    parameter int addr_w = 8,
    parameter int width  = 30,
    parameter int TO_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [width-1:0]  wr_data,
    output logic              wr_ready,
    input  logic              rd_valid,
    input  logic [addr_w-1:0] rd_index,
    output logic              rd_ready,
    output logic              rd_done,
    output logic [width-1:0]  rd_data,
    input  logic              mk_valid,
    input  logic              mk_set,
    input  logic [addr_w-1:0] mk_index,
    output logic              mk_ready,
    output logic              mk_done,
    output logic [width-1:0]  buf_in,
    output logic [addr_w-1:0] buf_index,
    output logic              buf_add,
    output logic              buf_remove,
    output logic              buf_mark,
    output logic              buf_un_mark,
    input  logic              buf_add_finish,
    input  logic              buf_remove_finish,
    input  logic              buf_mark_finish,
    input  logic              buf_un_mark_finish,
    input  logic [width-1:0]  buf_out,
    input  logic              buf_full,
    input  logic              buf_empty,
    output logic              hs_err
);
    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_RM, OP_MK, OP_UM} op_t;

    state_t state, state_n;
    op_t op, op_n;
    logic [3:0] stb;
    logic stb_n, fin, any_fin, take_rd, to_hit;
    logic wr_rdy_n, rd_rdy_n, mk_rdy_n, rd_done_n, mk_done_n, err_n;
    logic [addr_w-1:0] idx_n;
    logic [width-1:0] in_n, rdat_n;

    assign {buf_un_mark, buf_mark, buf_remove, buf_add} = stb;
    assign fin = op == OP_ADD ? buf_add_finish :
                 op == OP_RM  ? buf_remove_finish :
                 op == OP_MK  ? buf_mark_finish : buf_un_mark_finish;
    assign any_fin = buf_add_finish | buf_remove_finish | buf_mark_finish | buf_un_mark_finish;
    assign take_rd = rd_valid & ~buf_empty;

`ifdef BUFFER_PORT_CTRL_TIMEOUT_EN
    localparam int cw = $clog2(TO_CYC + 1);
    logic [cw-1:0] cnt;
    assign to_hit = state != IDLE && cnt == cw'(TO_CYC - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else cnt <= (state == IDLE || state_n != state) ? '0 : cnt + 1'b1;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        op_n = op;
        stb_n = 1'b0;
        idx_n = buf_index;
        in_n = buf_in;
        rdat_n = rd_data;
        wr_rdy_n = 1'b0;
        rd_rdy_n = 1'b0;
        mk_rdy_n = 1'b0;
        rd_done_n = 1'b0;
        mk_done_n = 1'b0;
        err_n = 1'b0;
        case (state)
            IDLE: begin
                if (take_rd) begin
                    rd_rdy_n = 1'b1;
                    idx_n = rd_index;
                    op_n = OP_RM;
                    state_n = REQ;
                end else if (mk_valid) begin
                    mk_rdy_n = 1'b1;
                    idx_n = mk_index;
                    op_n = mk_set ? OP_MK : OP_UM;
                    state_n = REQ;
                end else if (wr_valid & ~buf_full) begin
                    wr_rdy_n = 1'b1;
                    in_n = wr_data;
                    op_n = OP_ADD;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (fin) begin
                    state_n = REL;
                    rdat_n = op == OP_RM ? buf_out : rd_data;
                end else if (to_hit) begin
                    err_n = 1'b1;
                    state_n = REL;
                end else begin
                    // a strobe may only rise while every finish line is low
                    stb_n = (|stb) | ~any_fin;
                end
            end
            REL: begin
                if (!fin) begin
                    state_n = IDLE;
                    rd_done_n = op == OP_RM;
                    mk_done_n = op == OP_MK || op == OP_UM;
                end else if (to_hit) begin
                    err_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op <= OP_ADD;
            stb <= '0;
            buf_index <= '0;
            buf_in <= '0;
            rd_data <= '0;
            wr_ready <= 1'b0;
            rd_ready <= 1'b0;
            mk_ready <= 1'b0;
            rd_done <= 1'b0;
            mk_done <= 1'b0;
            hs_err <= 1'b0;
        end else begin
            state <= state_n;
            op <= op_n;
            stb <= stb_n ? 4'b0001 << op_n : 4'b0000;
            buf_index <= idx_n;
            buf_in <= in_n;
            rd_data <= rdat_n;
            wr_ready <= wr_rdy_n;
            rd_ready <= rd_rdy_n;
            mk_ready <= mk_rdy_n;
            rd_done <= rd_done_n;
            mk_done <= mk_done_n;
            hs_err <= err_n;
        end
    end
endmodule

// File: doc/buffer_port_ctrl.md
Name: buffer_port_ctrl

Overview:
- Clocked initiator for the NoC flit buffer's four-phase level handshakes (add/remove/mark/un_mark with matching *_finish acks).
- Turns router-side valid/ready write, read and mark requests into correctly sequenced buffer strobes: one operation in flight, full request/release handshake per operation.
- Sits between the router input-port logic and one flit buffer instance.

Parameters:
- addr_w, 8, buffer index width
- width, 30, flit width
- TO_CYC, 64, handshake timeout in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wr_valid  in  1  upstream flit valid
- wr_data  in  width  upstream flit
- wr_ready  out  1  flit accepted this cycle
- rd_valid  in  1  remove request
- rd_index  in  addr_w  slot to remove
- rd_ready  out  1  remove request accepted this cycle
- rd_done  out  1  one-cycle pulse, rd_data valid
- rd_data  out  width  removed flit (registered)
- mk_valid  in  1  mark/un_mark request
- mk_set  in  1  1 = mark, 0 = un_mark
- mk_index  in  addr_w  slot to mark
- mk_ready  out  1  mark request accepted
- mk_done  out  1  one-cycle pulse, mark op complete
- buf_in  out  width  flit to buffer
- buf_index  out  addr_w  index to buffer
- buf_add, buf_remove, buf_mark, buf_un_mark  out  1 each  buffer strobes
- buf_add_finish, buf_remove_finish, buf_mark_finish, buf_un_mark_finish  in  1 each  buffer acks
- buf_out  in  width  buffer read data
- buf_full, buf_empty  in  1 each  buffer status
- hs_err  out  1  timeout error pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async, rst=1): state IDLE; all buf_* strobes 0; buf_in, buf_index, rd_data = 0; all ready/done pulses 0; hs_err 0. Reset mid-operation drops strobes immediately; the op is abandoned and no done pulse is issued.
- All inputs are sampled at the rising clk edge; outputs are registered.
- States: IDLE, REQ, REL.
- IDLE, priority remove > mark > add. The accepted request's ready pulses high for that single cycle, operands are latched into buf_index/buf_in, and the op type is latched.
  - Remove: eligible only if rd_valid & ~buf_empty.
  - Mark/un_mark: eligible if mk_valid (no status condition).
  - Add: eligible only if wr_valid & ~buf_full.
  - Next state: REQ.
- REQ: the one matching strobe is held high. When its *_finish is sampled 1:
  - for remove, capture buf_out into rd_data;
  - drop the strobe;
  - go to REL.
- REL: all strobes low. When the matching *_finish is sampled 0:
  - pulse rd_done for remove or mk_done for mark/un_mark (add has no done; wr_ready is its completion);
  - go to IDLE.
- Minimum op: accept at edge N, strobe high N+1, finish seen N+2, strobe low N+2, finish low seen N+3, done pulse N+3, next accept N+4 or later.
- Never more than one strobe high; a strobe never rises while any *_finish is 1.
- buf_full/buf_empty are only examined in IDLE. A request blocked by status stays pending, readiness stays 0, and lower-priority eligible requests may proceed. The requester holds valid and operands stable until ready.
- Simultaneous rd_valid, mk_valid and wr_valid: exactly one is accepted per IDLE visit, per priority.
- Finish already 1 on entering REQ is taken as the ack. This is legal because the previous REL guaranteed it was 0.

Optional Feature:
- Macro: BUFFER_PORT_CTRL_TIMEOUT_EN.
- Defined: a cycle counter runs in REQ and REL and clears on every state change.
  - Reaching TO_CYC in REQ: drop the strobe, pulse hs_err one cycle, go to REL.
  - Reaching TO_CYC in REL: pulse hs_err, go to IDLE with no done pulse.
- Undefined: no counter; REQ/REL wait indefinitely; hs_err is constant 0.

Test Plan:
- Add: wr_valid=1, wr_data=0x155, buf_full=0, model acks after 1 cycle -> wr_ready pulse, buf_add high exactly one cycle, buf_in=0x155.
- Remove: rd_valid=1, rd_index=3, buf_out=0x2AA -> buf_remove with buf_index=3, rd_done pulse, rd_data=0x2AA held afterwards.
- Priority: rd_valid, mk_valid (mk_set=1, index 5) and wr_valid all high in the same cycle -> remove first, then buf_mark with index 5, then add; three distinct handshakes, never overlapping.
- Status blocking: buf_empty=1 with rd_valid=1 and wr_valid=1 -> add is accepted, rd_ready stays 0 until buf_empty=0.
- Reset mid-REQ: assert rst while buf_remove=1 -> buf_remove=0 asynchronously, no rd_done, IDLE after release.
- Timeout, with the macro and TO_CYC=4: finish never rises -> strobe drops after 4 cycles in REQ, hs_err pulses, no done pulse.
